lcd_fb_arbiter: RTL and testbench

Frame-buffer access controller between the LCD timing generator and a single-port pixel memory. It turns the generator's DEN/column/row scan into memory reads and returns aligned RGB pixels with delayed HD/VD/DE. It also accepts pixel writes from a drawing client, buffers them, and issues them only in cycles the scan-out does not own the memory port.

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_wr_fifo.sv | 79 +++++++
 rtl/lcd_fb_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_fb_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared constants and types for the LCD frame-buffer path.
//                Holds the default panel geometry, scan and memory widths, the
//                arbiter FSM state encoding and the display pipeline latency.
//  Revision    : 1.0  initial release
// ============================================================================
package lcd_pkg;

  // Default panel geometry (active area only)
  localparam int LCD_H_ACT = 800;
  localparam int LCD_V_ACT = 480;

  // Scan coordinate, memory address and pixel widths
  localparam int LCD_CW    = 11;   // column counter width
  localparam int LCD_RW    = 10;   // row counter width
  localparam int LCD_AW    = 19;   // covers 800*480 = 384000 words
  localparam int LCD_DW    = 24;   // RGB888

  // Cycles from the scan sample to the registered panel outputs:
  // address/strobe register, memory read, output register.
  localparam int LCD_LAT   = 3;

  // Arbiter state: waiting for the first frame start, or scanning out.
  typedef enum logic [0:0] {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } lcd_state_t;

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_wr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_wr_fifo
//  Description : Small synchronous FIFO buffering pixel writes until the
//                memory port is free. First-word-fall-through: dout always
//                shows the oldest entry while the FIFO is non-empty.
//  Ports       : clk   - clock
//                rst   - synchronous active-high reset (flushes contents)
//                push  - write din (ignored while full)
//                pop   - discard the head entry (ignored while empty)
//                din   - entry to store
//                dout  - head entry
//                full  - DEPTH entries held
//                empty - no entries held
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_wr_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4     // power of two, at least 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int             c_PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PW:0]  c_FULL_CNT = (c_PW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_PW:0]    r_count;

  logic             w_push;
  logic             w_pop;

  // Occupancy is tracked with an explicit counter so full/empty come
  // straight from registered state.
  assign full   = (r_count == c_FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PW + 1)'(1);
        2'b01:   r_count <= r_count - (c_PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : lcd_wr_fifo
`default_nettype wire

// File: rtl/lcd_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_fb_arbiter
//  Description : Frame-buffer access controller between the LCD timing
//                generator and a single-port pixel memory. Scan-out reads
//                own the port whenever DEN is high; buffered client writes
//                drain one per cycle in every other cycle. Panel outputs are
//                delayed so RGB, DE, HD and VD stay mutually aligned.
//  Ports       : CLK, RST           - pixel clock, sync active-high reset
//                den_i/hd_i/vd_i    - scan enables/syncs (syncs active low)
//                col_i/row_i        - scan position
//                wr_valid/wr_ready  - write handshake
//                wr_x/wr_y/wr_data  - write position and pixel
//                wr_drop            - pulse: accepted write was off-panel
//                mem_addr/mem_re/mem_we/mem_wdata/mem_rdata - memory port
//                rgb_o/de_o/hd_o/vd_o - aligned panel outputs
//                frame_o            - pulse after each vd_i falling edge
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_fb_arbiter
  import lcd_pkg::*;
#(
  parameter int H_ACT      = LCD_H_ACT,
  parameter int V_ACT      = LCD_V_ACT,
  parameter int AW         = LCD_AW,
  parameter int DW         = LCD_DW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  // scan side
  input  logic              den_i,
  input  logic              hd_i,
  input  logic              vd_i,
  input  logic [LCD_CW-1:0] col_i,
  input  logic [LCD_RW-1:0] row_i,
  // drawing client
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [LCD_CW-1:0] wr_x,
  input  logic [LCD_RW-1:0] wr_y,
  input  logic [DW-1:0]     wr_data,
  output logic              wr_drop,
  // pixel memory
  output logic [AW-1:0]     mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  // panel
  output logic [DW-1:0]     rgb_o,
  output logic              de_o,
  output logic              hd_o,
  output logic              vd_o,
  output logic              frame_o
);

  localparam int                c_FW    = AW + DW;
  localparam logic [LCD_CW-1:0] c_H_LIM = LCD_CW'(H_ACT);
  localparam logic [LCD_RW-1:0] c_V_LIM = LCD_RW'(V_ACT);

  lcd_state_t         r_state;
  logic               r_vd_prev;

  // Display delay line for the stages ahead of the output registers
  logic [LCD_LAT-2:0] r_de_d;
  logic [LCD_LAT-2:0] r_hd_d;
  logic [LCD_LAT-2:0] r_vd_d;

  logic               w_vd_fall;
  logic               w_rd_slot;
  logic               w_accept;
  logic               w_in_range;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [AW-1:0]      w_scan_addr;
  logic [AW-1:0]      w_wr_addr;
  logic [c_FW-1:0]    w_fifo_din;
  logic [c_FW-1:0]    w_fifo_dout;

  // --------------------------------------------------------------------------
  // Address generation: row-major frame buffer, row*H_ACT + col
  // --------------------------------------------------------------------------
  assign w_scan_addr = AW'(row_i) * AW'(H_ACT) + AW'(col_i);
  assign w_wr_addr   = AW'(wr_y) * AW'(H_ACT) + AW'(wr_x);

  assign w_vd_fall   = r_vd_prev && !vd_i;

  // A sampled DEN in ACTIVE claims the memory port for the next cycle.
  // Gating DEN here also keeps de_o low for everything sampled before the
  // first frame start.
  assign w_rd_slot   = den_i && (r_state == ACTIVE);

  // --------------------------------------------------------------------------
  // Write acceptance and buffering
  // --------------------------------------------------------------------------
  // wr_ready looks only at the registered occupancy; a pop in the same cycle
  // does not open a slot until the next cycle.
  assign wr_ready    = !w_full;
  assign w_accept    = wr_valid && wr_ready;
  assign w_in_range  = (wr_x < c_H_LIM) && (wr_y < c_V_LIM);
  assign w_push      = w_accept && w_in_range;
  assign w_pop       = !w_rd_slot && !w_empty;
  assign w_fifo_din  = {w_wr_addr, wr_data};

  lcd_wr_fifo #(
    .WIDTH (c_FW),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_fifo_din),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // --------------------------------------------------------------------------
  // Frame FSM: idle until the first vd_i falling edge, then scan forever.
  // frame_o is registered here alongside the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= WAIT_FRAME;
      r_vd_prev <= 1'b1;
      frame_o   <= 1'b0;
    end else begin
      r_vd_prev <= vd_i;
      frame_o   <= w_vd_fall;
      case (r_state)
        WAIT_FRAME: begin
          if (w_vd_fall) begin
            r_state <= ACTIVE;
          end
        end
        ACTIVE: begin
          r_state <= ACTIVE;
        end
        default: begin
          r_state <= WAIT_FRAME;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Memory port: scan reads take priority; otherwise drain one write.
  // Because the read slot is decided from the same sample that the write
  // pop looks at, a write to the pixel being scanned always lands after the
  // read of that pixel.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (w_rd_slot) begin
      mem_re    <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= w_scan_addr;
    end else if (w_pop) begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b1;
      mem_addr  <= w_fifo_dout[c_FW-1:DW];
      mem_wdata <= w_fifo_dout[DW-1:0];
    end else begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Out-of-range writes are consumed but never buffered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= w_accept && !w_in_range;
    end
  end

  // --------------------------------------------------------------------------
  // Display pipeline: DE/HD/VD travel alongside the memory read so that the
  // output register sees the delayed DE in the same cycle mem_rdata is valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_de_d <= '0;
      r_hd_d <= '1;
      r_vd_d <= '1;
      de_o   <= 1'b0;
      hd_o   <= 1'b1;
      vd_o   <= 1'b1;
      rgb_o  <= '0;
    end else begin
      r_de_d <= {r_de_d[LCD_LAT-3:0], w_rd_slot};
      r_hd_d <= {r_hd_d[LCD_LAT-3:0], hd_i};
      r_vd_d <= {r_vd_d[LCD_LAT-3:0], vd_i};
      de_o   <= r_de_d[LCD_LAT-2];
      hd_o   <= r_hd_d[LCD_LAT-2];
      vd_o   <= r_vd_d[LCD_LAT-2];
      rgb_o  <= r_de_d[LCD_LAT-2] ? mem_rdata : '0;
    end
  end

endmodule : lcd_fb_arbiter
`default_nettype wire

// File: tb/tb_lcd_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_fb_arbiter
//  Description : Self-checking bench for lcd_fb_arbiter. A behavioural frame
//                memory answers the DUT's memory port; a cycle-level reference
//                model (write queue, frame flag, delayed display entries)
//                predicts every DUT output. Directed scenarios first, then
//                randomized scan and write traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_fb_arbiter;

  localparam int H     = 800;
  localparam int V     = 480;
  localparam int NPIX  = H * V;
  localparam int DEPTH = 4;
  localparam int NMAX  = 8192;

  logic        CLK = 1'b0;
  logic        RST;
  logic        den_i, hd_i, vd_i;
  logic [10:0] col_i;
  logic [9:0]  row_i;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] wr_x;
  logic [9:0]  wr_y;
  logic [23:0] wr_data;
  logic        wr_drop;
  logic [18:0] mem_addr;
  logic        mem_re, mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic [23:0] rgb_o;
  logic        de_o, hd_o, vd_o, frame_o;

  always #5 CLK = ~CLK;

  lcd_fb_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .den_i     (den_i),
    .hd_i      (hd_i),
    .vd_i      (vd_i),
    .col_i     (col_i),
    .row_i     (row_i),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .wr_drop   (wr_drop),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rgb_o     (rgb_o),
    .de_o      (de_o),
    .hd_o      (hd_o),
    .vd_o      (vd_o),
    .frame_o   (frame_o)
  );

  // ---------------------------------------------------------------------
  // Behavioural frame memory: unwritten words hold an address pattern.
  // ---------------------------------------------------------------------
  logic [23:0] fbm   [0:NPIX-1];
  bit          fbm_w [0:NPIX-1];

  function automatic logic [23:0] pix(input int a);
    if (a < 0 || a >= NPIX) return 24'h0;
    return fbm_w[a] ? fbm[a] : 24'(a * 7919 + 13);
  endfunction

  always @(posedge CLK) begin
    if (mem_we && int'(mem_addr) < NPIX) begin
      fbm[mem_addr]   <= mem_wdata;
      fbm_w[mem_addr] <= 1'b1;
    end
    if (mem_re) begin
      mem_rdata <= pix(int'(mem_addr));
    end
  end

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", tag, got, exp, k);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [18:0] a;
    logic [23:0] d;
  } wr_t;

  wr_t         q[$];          // writes waiting for the memory port, in order
  bit          m_active;      // a frame has started since reset
  bit          m_vdprev;
  // Display entry per step (offset by 2 so the first checks see reset values)
  bit          e_de   [0:NMAX+1];
  bit          e_hd   [0:NMAX+1];
  bit          e_vd   [0:NMAX+1];
  logic [18:0] e_addr [0:NMAX+1];
  logic [23:0] e_rgb  [0:NMAX+1];

  // Apply the current inputs for one clock, predict, then check.
  task automatic step();
    bit          re, acc, inr, pop, fr, drop;
    logic [18:0] sa;
    wr_t         pe, nw;
    int          i;
    i = k + 2;
    re = 0; acc = 0; inr = 0; pop = 0; fr = 0; drop = 0;
    sa = '0; pe = '0; nw = '0;
    if (RST) begin
      q.delete();
      m_active = 0;
      m_vdprev = 1;
      for (int j = i - 2; j <= i; j++) begin
        e_de[j] = 0; e_hd[j] = 1; e_vd[j] = 1; e_addr[j] = '0; e_rgb[j] = '0;
      end
    end else begin
      re   = den_i && m_active;
      sa   = 19'(int'(row_i) * H + int'(col_i));
      acc  = wr_valid && (q.size() < DEPTH);
      inr  = (int'(wr_x) < H) && (int'(wr_y) < V);
      drop = acc && !inr;
      if (!re && q.size() > 0) begin
        pop = 1;
        pe  = q.pop_front();
      end
      if (acc && inr) begin
        nw.a = 19'(int'(wr_y) * H + int'(wr_x));
        nw.d = wr_data;
        q.push_back(nw);
      end
      fr       = m_vdprev && !vd_i;
      m_vdprev = vd_i;
      e_de[i]  = re;
      e_hd[i]  = hd_i;
      e_vd[i]  = vd_i;
      e_addr[i] = sa;
      if (fr) m_active = 1;
    end

    @(posedge CLK);
    #1;

    chk("mem_re", mem_re, re);
    chk("mem_we", mem_we, pop);
    if (re) chk("rd_addr", mem_addr, sa);
    if (pop) begin
      chk("wr_addr", mem_addr, pe.a);
      chk("wr_data", mem_wdata, pe.d);
    end
    chk("wr_drop", wr_drop, drop);
    chk("frame_o", frame_o, fr);
    chk("wr_ready", wr_ready, (q.size() < DEPTH));
    // Memory now holds every write issued up to the read edge.
    e_rgb[i] = e_de[i] ? pix(int'(e_addr[i])) : 24'h0;
    chk("de_o", de_o, e_de[i-2]);
    chk("hd_o", hd_o, e_hd[i-2]);
    chk("vd_o", vd_o, e_vd[i-2]);
    chk("rgb_o", rgb_o, e_rgb[i-2]);
    k++;
  endtask

  task automatic drive(input bit rst, input bit den, input bit hd, input bit vd,
                       input int col, input int row, input bit wv,
                       input int wx, input int wy, input logic [23:0] wd);
    RST      = rst;
    den_i    = den;
    hd_i     = hd;
    vd_i     = vd;
    col_i    = 11'(col);
    row_i    = 10'(row);
    wr_valid = wv;
    wr_x     = 11'(wx);
    wr_y     = 10'(wy);
    wr_data  = wd;
    step();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 24'h0);
  endtask

  initial begin
    for (int j = 0; j < NMAX + 2; j++) begin
      e_de[j] = 0; e_hd[j] = 1; e_vd[j] = 1; e_addr[j] = '0; e_rgb[j] = '0;
    end
    m_active = 0;
    m_vdprev = 1;

    // Reset held two cycles, then idle
    repeat (2) drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 24'h0);
    chk("rst_mem_addr", mem_addr, 19'd0);
    chk("rst_mem_wdata", mem_wdata, 24'd0);
    idle(2);

    // DEN before any frame start: no read, de_o stays low
    repeat (2) drive(0, 1, 1, 1, 3, 1, 0, 0, 0, 24'h0);

    // Frame start, then one scan sample at row 2 col 5
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 24'h0);
    drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 24'h0);
    drive(0, 1, 1, 1, 5, 2, 0, 0, 0, 24'h0);
    chk("scan_addr_1605", mem_addr, 19'd1605);
    idle(2);
    chk("pix_1605", rgb_o, pix(1605));
    chk("pix_1605_de", de_o, 1'b1);
    idle(1);

    // Five back-to-back writes during an active line
    for (int n = 0; n < 5; n++)
      drive(0, 1, 1, 1, 10 + n, 3, 1, 100 + n, 7, 24'hA00000 + 24'(n));
    repeat (2) drive(0, 1, 1, 1, 20, 3, 0, 0, 0, 24'h0);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0, 24'h0);
    idle(7);

    // Off-panel write
    drive(0, 0, 1, 1, 0, 0, 1, 800, 0, 24'h123456);
    idle(3);

    // Three writes held, then push and pop in one blanking cycle
    for (int n = 0; n < 3; n++)
      drive(0, 1, 1, 1, 30 + n, 4, 1, 200 + n, 9, 24'hB00000 + 24'(n));
    drive(0, 0, 1, 1, 0, 0, 1, 210, 9, 24'hB0000F);
    idle(6);

    // Reset mid-line with two writes pending
    drive(0, 1, 1, 1, 40, 5, 1, 300, 11, 24'hC00001);
    drive(0, 1, 1, 1, 41, 5, 1, 301, 11, 24'hC00002);
    drive(1, 1, 1, 1, 42, 5, 0, 0, 0, 24'h0);
    chk("post_rst_we", mem_we, 1'b0);
    chk("post_rst_ready", wr_ready, 1'b1);
    idle(6);

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      drive(($urandom_range(0, 999) == 0),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 15) != 0),
            ($urandom_range(0, 49) != 0),
            int'($urandom_range(0, H - 1)),
            int'($urandom_range(0, V - 1)),
            ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, 839)),
            int'($urandom_range(0, 499)),
            24'($urandom));
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lcd_fb_arbiter
`default_nettype wire
